// File: rtl/fetch_pkg.sv
// Purpose : shared types and constants for the instruction fetch slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch sequencing: RUN issues requests, DRAIN discards responses that
    // belong to a path abandoned by a redirect.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int XLEN_DEFAULT = 32;

    // Byte stride between consecutive instructions; also the fetch alignment.
    localparam int INSTR_ALIGN = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : synchronous DEPTH x WIDTH queue with flush, count, full and empty.
// Latency : push visible at pop_dat one cycle later; pop_dat is combinational from head.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   push, push_dat      write one entry at the tail
//   pop                 retire the head entry
//   flush               empty the queue this cycle
//   pop_dat             head entry (valid when !empty)
//   count, full, empty  occupancy status
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch with credit-limited requests, in-order queue and redirect flush.
// Latency : request address combinational from fetch_pc; response reaches out_* one cycle later.
// Backpressure: requests stop when queued + in-flight reaches DEPTH; out_ready stalls the queue head.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel (word aligned)
//   imem_rsp_valid/data            in-order instruction return, no backpressure
//   out_valid/ready/instr/pc       decoded-side instruction stream
//   redirect_valid/pc              taken branch/jump: flush and refetch from redirect_pc
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_ALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_ALIGN - 1);

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   stale;
    logic [CW-1:0]   eff_inflight;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_aligned;
    logic            accept;
    logic            rsp_take;
    logic            q_push;
    logic            q_pop;
    logic [2*XLEN-1:0] q_head;

    assign redirect_aligned = redirect_pc & ~ALIGN_MASK;

    // Queue slots already filled plus responses still owed; one extra bit so
    // the sum cannot wrap before the compare.
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req_valid = (state == RUN) && (occupancy < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept   = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding cannot belong to us (e.g. a request
    // issued before reset), so it is dropped without touching any counter.
    assign rsp_take = imem_rsp_valid && (inflight != '0);

    // Redirect kills this cycle's response and pop; responses in DRAIN are stale.
    assign q_push = rsp_take && (state == RUN) && !redirect_valid && !q_full;
    assign q_pop  = out_valid && out_ready && !redirect_valid;

    // Outstanding count after this cycle's accept and response are applied.
    always_comb begin
        eff_inflight = inflight;
        if (accept && !rsp_take) begin
            eff_inflight = inflight + CW'(1);
        end else if (!accept && rsp_take) begin
            eff_inflight = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            target   <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
        end else begin
            inflight <= eff_inflight;
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        if (eff_inflight == '0) begin
                            fetch_pc <= redirect_aligned;
                            rsp_pc   <= redirect_aligned;
                        end else begin
                            // Every request still owed, including one accepted
                            // right now, returns on the abandoned path.
                            state  <= DRAIN;
                            target <= redirect_aligned;
                            stale  <= eff_inflight;
                        end
                    end else begin
                        if (accept) begin
                            fetch_pc <= fetch_pc + STEP;
                        end
                        if (rsp_take) begin
                            rsp_pc <= rsp_pc + STEP;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        target <= redirect_aligned;
                    end
                    if (rsp_take) begin
                        stale <= stale - CW'(1);
                        if (stale == CW'(1)) begin
                            // A redirect arriving on the final stale response
                            // must still take effect.
                            state    <= RUN;
                            fetch_pc <= redirect_valid ? redirect_aligned : target;
                            rsp_pc   <= redirect_valid ? redirect_aligned : target;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat ({rsp_pc, imem_rsp_data}),
        .pop      (q_pop),
        .flush    (redirect_valid),
        .pop_dat  (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign out_valid = !q_empty;
    assign out_pc    = q_head[2*XLEN-1:XLEN];
    assign out_instr = q_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed self-checking bench for fetch_unit with an in-order 1-cycle memory model.
// Latency : memory answers each accepted request on the following cycle when enabled.
// Backpressure: memory responses can be held back to build up in-flight requests.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    logic        mem_en   = 1'b1;
    logic [31:0] pending [$];

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: record any handshake at the edge, then drive the memory
    // response for the new cycle. Outputs are sampled 1 ns after the edge.
    task automatic tick();
        logic        acc;
        logic        rst_s;
        logic [31:0] a;
        acc   = imem_req_valid && imem_req_ready;
        a     = imem_req_addr;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            pending.delete();
        end else if (acc) begin
            pending.push_back(a);
            n_acc++;
        end
        if (mem_en && pending.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and first-cycle request
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_req_addr", imem_req_addr, 32'h0000_0000);
        chk("reset_req_valid", 32'(imem_req_valid), 32'd1);

        // Streaming: one instruction per cycle once the pipe fills
        out_ready = 1'b1;
        tick();
        chk("stream_fill_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("stream_first_valid", 32'(out_valid), 32'd1);
        chk("stream_first_pc", out_pc, 32'h0000_0000);
        chk("stream_first_instr", out_instr, 32'h5A5A_0000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("stream_pc", out_pc, 32'(4 * i));
            chk("stream_instr", out_instr, 32'(4 * i) ^ 32'h5A5A_0000);
        end

        // Stalled consumer: credits cap requests at queue depth
        do_reset();
        out_ready = 1'b0;
        n_acc = 0;
        repeat (8) tick();
        chk("stall_request_count", 32'(n_acc), 32'd4);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_pc", out_pc, 32'h0000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_pop_next_pc", out_pc, 32'h0000_0004);
        chk("stall_pop_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stall_pop_req_addr", imem_req_addr, 32'h0000_0010);

        // Redirect to 0x103 with three requests outstanding
        do_reset();
        out_ready = 1'b1;
        mem_en = 1'b0;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_req_valid0", 32'(imem_req_valid), 32'd0);
        mem_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
        end
        tick();
        chk("drain_exit_req_valid", 32'(imem_req_valid), 32'd1);
        chk("drain_exit_req_addr", imem_req_addr, 32'h0000_0100);
        chk("drain_exit_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        chk("drain_first_out_valid", 32'(out_valid), 32'd1);
        chk("drain_first_out_pc", out_pc, 32'h0000_0100);
        chk("drain_first_instr", out_instr, 32'h5A5A_0100);

        // Redirect together with pop, response and request acceptance
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        chk("race_pre_pc", out_pc, 32'h0000_0008);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("race_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("race_drained_out_valid", 32'(out_valid), 32'd0);
        chk("race_req_valid", 32'(imem_req_valid), 32'd1);
        chk("race_req_addr", imem_req_addr, 32'h0000_0200);
        tick();
        tick();
        chk("race_first_pc", out_pc, 32'h0000_0200);
        chk("race_first_instr", out_instr, 32'h5A5A_0200);

        // Idle redirect (low bits dropped) and address wrap
        do_reset();
        imem_req_ready = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_out_valid", 32'(out_valid), 32'd0);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        tick();
        chk("wrap_out_pc_top", out_pc, 32'hFFFF_FFFC);
        chk("wrap_out_instr_top", out_instr, 32'hA5A5_FFFC);
        tick();
        chk("wrap_out_pc_zero", out_pc, 32'h0000_0000);

        // Reset while draining two stale responses
        do_reset();
        mem_en = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("rstdrain_in_drain", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdrain_out_valid", 32'(out_valid), 32'd0);
        chk("rstdrain_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rstdrain_req_addr", imem_req_addr, 32'h0000_0000);
        imem_req_ready = 1'b1;
        mem_en = 1'b1;
        tick();
        tick();
        chk("rstdrain_first_valid", 32'(out_valid), 32'd1);
        chk("rstdrain_first_pc", out_pc, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
